// File: rtl/gpio_irq_if.sv
// gpio_irq_if: standard peripheral bus between a bus master and gpio_irq.
//   cs_      chip select, active low        (master -> slave)
//   as_      address strobe, active low     (master -> slave)
//   rw       1 = read, 0 = write            (master -> slave)
//   addr     register address               (master -> slave)
//   wr_data  write data                     (master -> slave)
//   rd_data  registered read data           (slave -> master)
//   rdy_     registered ready, active low   (slave -> master)
interface gpio_irq_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
);
    logic              cs_;
    logic              as_;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    logic              rdy_;

    modport master (
        output cs_, as_, rw, addr, wr_data,
        input  rd_data, rdy_
    );

    modport slave (
        input  cs_, as_, rw, addr, wr_data,
        output rd_data, rdy_
    );
endinterface

// File: rtl/gpio_irq.sv
// gpio_irq: GPIO controller with input, output and bidirectional channels,
// multi-stage input synchronisers, an output toggle register and per-input
// edge interrupts (selectable polarity, sticky W1C status, mask).
// Ports:
//   clk       clock, rising edge
//   reset     asynchronous, active-high reset
//   bus       gpio_irq_if slave (cs_/as_/rw/addr/wr_data/rd_data/rdy_)
//   gpio_in   input-only pins
//   gpio_out  output-only pins (OUT_DATA)
//   gpio_io   bidirectional pins, driven where IO_DIR = 1
//   irq       registered level interrupt = |(IRQ_STAT & IRQ_MASK)
module gpio_irq #(
    parameter int IN_CH       = 16,
    parameter int OUT_CH      = 16,
    parameter int IO_CH       = 16,
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    gpio_irq_if.slave         bus,
    input  logic [IN_CH-1:0]  gpio_in,
    output logic [OUT_CH-1:0] gpio_out,
    inout  wire  [IO_CH-1:0]  gpio_io,
    output logic              irq
);
    typedef enum logic [ADDR_W-1:0] {
        REG_IN_DATA  = ADDR_W'(0),
        REG_OUT_DATA = ADDR_W'(1),
        REG_IO_DATA  = ADDR_W'(2),
        REG_IO_DIR   = ADDR_W'(3),
        REG_IRQ_MASK = ADDR_W'(4),
        REG_IRQ_POL  = ADDR_W'(5),
        REG_IRQ_STAT = ADDR_W'(6),
        REG_OUT_TGL  = ADDR_W'(7)
    } reg_addr_e;

    localparam int               ARM_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);

    logic [IN_CH-1:0]  in_sr [SYNC_STAGES];
    logic [IO_CH-1:0]  io_sr [SYNC_STAGES];
    logic [IN_CH-1:0]  in_sync;
    logic [IN_CH-1:0]  in_prev;
    logic [IN_CH-1:0]  irq_mask;
    logic [IN_CH-1:0]  irq_pol;
    logic [IN_CH-1:0]  irq_stat;
    logic [IN_CH-1:0]  stat_next;
    logic [IN_CH-1:0]  edge_evt;
    logic [OUT_CH-1:0] out_data;
    logic [IO_CH-1:0]  io_sync;
    logic [IO_CH-1:0]  io_out;
    logic [IO_CH-1:0]  io_dir;
    logic [IO_CH-1:0]  io_rd;
    logic [ARM_W-1:0]  arm_cnt;
    logic              armed;
    logic              sel;
    logic              wr_en;
    logic [DATA_W-1:0] rd_mux;

    assign in_sync  = in_sr[SYNC_STAGES-1];
    assign io_sync  = io_sr[SYNC_STAGES-1];
    assign sel      = !bus.cs_ && !bus.as_;
    assign wr_en    = sel && !bus.rw;
    assign gpio_out = out_data;

    // Edge detection stays off until the synchronisers have flushed the
    // reset zeros, so a pin held high through reset is not seen as a rise.
    assign armed    = (arm_cnt == ARM_DONE);
    assign edge_evt = armed ? ((in_sync & ~in_prev & ~irq_pol) |
                               (~in_sync & in_prev & irq_pol)) : '0;

    // Output-direction bits read back the driven value, inputs the pin.
    assign io_rd = (io_dir & io_out) | (~io_dir & io_sync);

    for (genvar gi = 0; gi < IO_CH; gi++) begin : g_io_drv
        assign gpio_io[gi] = io_dir[gi] ? io_out[gi] : 1'bz;
    end

    // W1C is applied before OR-ing new events so a coincident event wins.
    always_comb begin
        stat_next = irq_stat;
        if (wr_en && bus.addr == REG_IRQ_STAT)
            stat_next = stat_next & ~bus.wr_data[IN_CH-1:0];
        stat_next = stat_next | edge_evt;
    end

    always_comb begin
        rd_mux = '0;
        case (bus.addr)
            REG_IN_DATA:  rd_mux[IN_CH-1:0]  = in_sync;
            REG_OUT_DATA: rd_mux[OUT_CH-1:0] = out_data;
            REG_IO_DATA:  rd_mux[IO_CH-1:0]  = io_rd;
            REG_IO_DIR:   rd_mux[IO_CH-1:0]  = io_dir;
            REG_IRQ_MASK: rd_mux[IN_CH-1:0]  = irq_mask;
            REG_IRQ_POL:  rd_mux[IN_CH-1:0]  = irq_pol;
            REG_IRQ_STAT: rd_mux[IN_CH-1:0]  = irq_stat;
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                in_sr[i] <= '0;
                io_sr[i] <= '0;
            end
            in_prev     <= '0;
            arm_cnt     <= '0;
            irq_stat    <= '0;
            irq_mask    <= '0;
            irq_pol     <= '0;
            out_data    <= '0;
            io_out      <= '0;
            io_dir      <= '0;
            irq         <= 1'b0;
            bus.rdy_    <= 1'b1;
            bus.rd_data <= '0;
        end else begin
            in_sr[0] <= gpio_in;
            io_sr[0] <= gpio_io;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                in_sr[i] <= in_sr[i-1];
                io_sr[i] <= io_sr[i-1];
            end
            in_prev  <= in_sync;
            if (!armed)
                arm_cnt <= arm_cnt + 1'b1;
            irq_stat <= stat_next;
            irq      <= |(irq_stat & irq_mask);

            bus.rdy_    <= !sel;
            bus.rd_data <= (sel && bus.rw) ? rd_mux : '0;

            if (wr_en) begin
                case (bus.addr)
                    REG_OUT_DATA: out_data <= bus.wr_data[OUT_CH-1:0];
                    REG_IO_DATA:  io_out   <= bus.wr_data[IO_CH-1:0];
                    REG_IO_DIR:   io_dir   <= bus.wr_data[IO_CH-1:0];
                    REG_IRQ_MASK: irq_mask <= bus.wr_data[IN_CH-1:0];
                    REG_IRQ_POL:  irq_pol  <= bus.wr_data[IN_CH-1:0];
                    REG_OUT_TGL:  out_data <= out_data ^ bus.wr_data[OUT_CH-1:0];
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_gpio_irq.sv
// tb_gpio_irq: directed test-plan steps followed by randomized bus/pin
// traffic, all checked against a behavioural model kept in this file.
module tb_gpio_irq;
    localparam int S = 2;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic [15:0] gpio_in   = 16'h000a;
    logic [15:0] gpio_out;
    wire  [15:0] gpio_io;
    logic        irq;
    logic [15:0] io_drv    = '0;
    logic        io_drv_en = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    gpio_irq_if #(.DATA_W(32), .ADDR_W(3)) bus ();

    gpio_irq #(
        .IN_CH(16), .OUT_CH(16), .IO_CH(16),
        .DATA_W(32), .ADDR_W(3), .SYNC_STAGES(S)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .gpio_in(gpio_in), .gpio_out(gpio_out),
        .gpio_io(gpio_io), .irq(irq)
    );

    assign gpio_io = io_drv_en ? io_drv : 16'bz;

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [15:0] m_out, m_io_out, m_dir, m_mask, m_pol, m_stat;
    logic        m_irq, m_rdy;
    logic [31:0] m_rd;
    logic [15:0] in_hist[$];
    logic [15:0] io_hist[$];
    int unsigned n_edges;

    function automatic void model_reset();
        m_out = '0; m_io_out = '0; m_dir = '0; m_mask = '0; m_pol = '0; m_stat = '0;
        m_irq = 1'b0; m_rdy = 1'b1; m_rd = '0;
        in_hist.delete();
        io_hist.delete();
        repeat (S + 1) begin
            in_hist.push_back('0);
            io_hist.push_back('0);
        end
        n_edges = 0;
    endfunction

    // One rising edge: a pin change is seen by the registers S edges later,
    // edges are judged on consecutive synchronised values, and nothing counts
    // during the first S+1 edges after reset.
    function automatic void model_step();
        logic [15:0] s_in, p_in, s_io, ev, wd;
        logic [31:0] rv;
        logic        sel;
        in_hist.push_back(gpio_in);
        io_hist.push_back(io_drv_en ? io_drv : (m_io_out & m_dir));
        while (in_hist.size() > S + 2) void'(in_hist.pop_front());
        while (io_hist.size() > S + 2) void'(io_hist.pop_front());
        s_in = in_hist[in_hist.size() - 1 - S];
        p_in = in_hist[in_hist.size() - 2 - S];
        s_io = io_hist[io_hist.size() - 1 - S];
        n_edges++;
        ev = '0;
        if (n_edges >= S + 2)
            for (int b = 0; b < 16; b++)
                if (s_in[b] != p_in[b] && s_in[b] != m_pol[b]) ev[b] = 1'b1;

        case (bus.addr)
            3'd0: rv = {16'd0, s_in};
            3'd1: rv = {16'd0, m_out};
            3'd2: rv = {16'd0, (m_dir & m_io_out) | (~m_dir & s_io)};
            3'd3: rv = {16'd0, m_dir};
            3'd4: rv = {16'd0, m_mask};
            3'd5: rv = {16'd0, m_pol};
            3'd6: rv = {16'd0, m_stat};
            default: rv = '0;
        endcase
        sel = !bus.cs_ && !bus.as_;
        wd  = bus.wr_data[15:0];
        m_irq = (m_stat & m_mask) != 0;
        m_rdy = !sel;
        m_rd  = (sel && bus.rw) ? rv : '0;
        if (sel && !bus.rw && bus.addr == 3'd6) m_stat = m_stat & ~wd;
        m_stat = m_stat | ev;
        if (sel && !bus.rw)
            case (bus.addr)
                3'd1: m_out    = wd;
                3'd2: m_io_out = wd;
                3'd3: m_dir    = wd;
                3'd4: m_mask   = wd;
                3'd5: m_pol    = wd;
                3'd7: m_out    = m_out ^ wd;
                default: ;
            endcase
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("rdy_", 32'(bus.rdy_), 32'(m_rdy));
        chk("rd_data", bus.rd_data, m_rd);
        chk("irq", 32'(irq), 32'(m_irq));
        chk("gpio_out", 32'(gpio_out), 32'(m_out));
    endtask

    task automatic acc(input logic r, input logic [2:0] a, input logic [31:0] d);
        bus.cs_ = 1'b0; bus.as_ = 1'b0; bus.rw = r; bus.addr = a; bus.wr_data = d;
        tick();
    endtask

    task automatic idle(input int n);
        bus.cs_ = 1'b1; bus.as_ = 1'b1;
        repeat (n) tick();
    endtask

    task automatic hold_reset_and_release();
        bus.cs_ = 1'b1; bus.as_ = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst rdy_", 32'(bus.rdy_), 32'h1);
        chk("rst rd_data", bus.rd_data, 32'h0);
        chk("rst irq", 32'(irq), 32'h0);
        chk("rst gpio_out", 32'(gpio_out), 32'h0);
        model_reset();
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.cs_ = 1'b1; bus.as_ = 1'b1; bus.rw = 1'b1; bus.addr = '0; bus.wr_data = '0;
        model_reset();
        hold_reset_and_release();

        // pin held high through reset: readable, no spurious event
        idle(4);
        acc(1'b1, 3'd0, 32'h0);
        chk("in_data", bus.rd_data, 32'h0000_000a);
        chk("in_data rdy_", 32'(bus.rdy_), 32'h0);
        acc(1'b1, 3'd6, 32'h0);
        chk("stat after reset", bus.rd_data, 32'h0);

        // OUT_DATA and OUT_TGL
        acc(1'b0, 3'd1, 32'h56);
        chk("gpio_out wr", 32'(gpio_out), 32'h56);
        acc(1'b0, 3'd7, 32'h0f);
        chk("gpio_out tgl", 32'(gpio_out), 32'h59);
        acc(1'b1, 3'd1, 32'h0);
        chk("out_data rd", bus.rd_data, 32'h59);
        acc(1'b1, 3'd7, 32'h0);
        chk("out_tgl rd", bus.rd_data, 32'h0);

        // bidirectional pins
        io_drv = 16'h0024; io_drv_en = 1'b1;
        idle(3);
        acc(1'b1, 3'd2, 32'h0);
        chk("io_data in", bus.rd_data, 32'h24);
        acc(1'b0, 3'd2, 32'h59);
        io_drv_en = 1'b0;
        acc(1'b0, 3'd3, 32'hffff);
        chk("gpio_io drive", 32'(gpio_io), 32'h0059);
        acc(1'b1, 3'd2, 32'h0);
        chk("io_data out", bus.rd_data, 32'h59);
        acc(1'b0, 3'd3, 32'h0);
        io_drv_en = 1'b1;
        idle(1);

        // rising-edge interrupt on bit 0, latency from the pin change
        acc(1'b0, 3'd4, 32'h1);
        acc(1'b0, 3'd5, 32'h0);
        idle(1);
        gpio_in = 16'h000b;
        idle(3);
        chk("irq before e4", 32'(irq), 32'h0);
        acc(1'b1, 3'd6, 32'h0);
        chk("stat at e3", bus.rd_data, 32'h1);
        chk("irq at e4", 32'(irq), 32'h1);
        gpio_in = 16'h000a;
        idle(5);
        acc(1'b1, 3'd6, 32'h0);
        chk("no falling event", bus.rd_data, 32'h1);
        acc(1'b0, 3'd6, 32'h1);
        idle(1);
        chk("irq after w1c", 32'(irq), 32'h0);

        // W1C coinciding with a new event: the event wins
        gpio_in = 16'h000b; idle(4);
        chk("irq set again", 32'(irq), 32'h1);
        gpio_in = 16'h000a; idle(4);
        gpio_in = 16'h000b; idle(2);
        acc(1'b0, 3'd6, 32'h1);
        idle(1);
        chk("irq kept", 32'(irq), 32'h1);
        acc(1'b1, 3'd6, 32'h0);
        chk("stat kept", bus.rd_data, 32'h1);
        acc(1'b0, 3'd6, 32'h1);
        idle(2);

        // masked event, then unmask
        acc(1'b0, 3'd4, 32'h0);
        gpio_in = 16'h0002; idle(4);
        gpio_in = 16'h000a; idle(4);
        acc(1'b1, 3'd6, 32'h0);
        chk("stat masked", bus.rd_data, 32'h8);
        chk("irq masked", 32'(irq), 32'h0);
        acc(1'b0, 3'd4, 32'h8);
        idle(1);
        chk("irq unmasked", 32'(irq), 32'h1);

        // async reset in the middle of a read
        acc(1'b1, 3'd0, 32'h0);
        #2;
        reset = 1'b1;
        #1;
        chk("mid rdy_", 32'(bus.rdy_), 32'h1);
        chk("mid rd_data", bus.rd_data, 32'h0);
        chk("mid irq", 32'(irq), 32'h0);
        hold_reset_and_release();

        // randomized traffic (IO_DIR stays 0 so the bench may drive gpio_io)
        for (int i = 0; i < 600; i++) begin
            logic [2:0] a;
            logic       r;
            int         k;
            if (i % 4 == 0) gpio_in = 16'($urandom);
            else            gpio_in = gpio_in ^ (16'h1 << $urandom_range(15, 0));
            io_drv = 16'($urandom);
            a = 3'($urandom_range(7, 0));
            r = 1'($urandom_range(1, 0));
            if (a == 3'd3) r = 1'b1;
            k = $urandom_range(4, 0);
            if (k == 0) idle(1);
            else if (k == 1) begin
                bus.cs_ = 1'b0; bus.as_ = 1'b1; bus.rw = r; bus.addr = a;
                tick();
            end else acc(r, a, $urandom);
        end
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
